// File: rtl/sopc_data_bus.sv
//------------------------------------------------------------------------------
// Module      : sopc_data_bus
// Description : CPU data-port interconnect with base/mask decode, per-slave
//               wait states and bus-error reporting for unmapped addresses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sopc_data_bus #(
    parameter int                       NSLV     = 4,
    parameter int                       DATA_W   = 32,
    parameter int                       ADDR_W   = 32,
    parameter logic [NSLV*ADDR_W-1:0]   SLV_BASE = '0,
    parameter logic [NSLV*ADDR_W-1:0]   SLV_MASK = '0,
    parameter logic [NSLV*4-1:0]        SLV_WAIT = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_ce_i,
    input  logic                   cpu_we_i,
    input  logic [ADDR_W-1:0]      cpu_addr_i,
    input  logic [DATA_W/8-1:0]    cpu_sel_i,
    input  logic [DATA_W-1:0]      cpu_data_i,
    output logic [DATA_W-1:0]      cpu_data_o,
    output logic                   cpu_stall_o,
    output logic                   cpu_err_o,
    output logic [ADDR_W-1:0]      err_addr_o,
    output logic [NSLV-1:0]        slv_ce_o,
    output logic                   slv_we_o,
    output logic [ADDR_W-1:0]      slv_addr_o,
    output logic [DATA_W/8-1:0]    slv_sel_o,
    output logic [DATA_W-1:0]      slv_data_o,
    input  logic [NSLV*DATA_W-1:0] slv_data_i
);

    localparam int c_IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic [c_IDX_W-1:0]   r_cur;
    logic [ADDR_W-1:0]    r_err_addr;

    logic [NSLV-1:0]      w_match;
    logic [DATA_W-1:0]    w_rdata    [NSLV];
    logic [3:0]           w_wait_tab [NSLV];
    logic                 w_hit;
    logic [c_IDX_W-1:0]   w_idx;
    logic [3:0]           w_wait;

    logic [NSLV-1:0]      w_ce;
    logic                 w_we;
    logic                 w_stall;
    logic                 w_err;
    logic [DATA_W-1:0]    w_cpu_rdata;

    genvar g;
    generate
        for (g = 0; g < NSLV; g++) begin : g_slave
            assign w_rdata[g]    = slv_data_i[g*DATA_W +: DATA_W];
            assign w_wait_tab[g] = SLV_WAIT[g*4 +: 4];
            assign w_match[g]    = ((cpu_addr_i & SLV_MASK[g*ADDR_W +: ADDR_W]) ==
                                    (SLV_BASE[g*ADDR_W +: ADDR_W] & SLV_MASK[g*ADDR_W +: ADDR_W]));
        end
    endgenerate

    // Scan downwards so that the lowest-indexed matching slave is the one kept.
    always_comb begin
        w_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_idx = c_IDX_W'(i);
            end
        end
    end

    assign w_hit  = |w_match;
    assign w_wait = w_wait_tab[w_idx];

    always_comb begin
        w_ce        = '0;
        w_we        = 1'b0;
        w_stall     = 1'b0;
        w_err       = 1'b0;
        w_cpu_rdata = '0;
        if (!rst && cpu_ce_i) begin
            if (r_state == S_IDLE) begin
                if (!w_hit) begin
                    w_err = 1'b1;
                end else begin
                    w_ce[w_idx] = 1'b1;
                    if (w_wait == 4'd0) begin
                        w_we = cpu_we_i;
                        if (!cpu_we_i) begin
                            w_cpu_rdata = w_rdata[w_idx];
                        end
                    end else begin
                        w_stall = 1'b1;
                    end
                end
            end else begin
                w_ce[r_cur] = 1'b1;
                if (r_cnt != 4'd0) begin
                    w_stall = 1'b1;
                end else begin
                    w_we = cpu_we_i;
                    if (!cpu_we_i) begin
                        w_cpu_rdata = w_rdata[r_cur];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_cur      <= '0;
            r_err_addr <= '0;
        end else if (r_state == S_IDLE) begin
            if (cpu_ce_i) begin
                if (!w_hit) begin
                    r_err_addr <= cpu_addr_i;
                end else if (w_wait != 4'd0) begin
                    r_cur   <= w_idx;
                    r_cnt   <= w_wait - 4'd1;
                    r_state <= S_WAIT;
                end
            end
        end else begin
            // A dropped request is a pipeline flush: leave without strobing.
            if (!cpu_ce_i || r_cnt == 4'd0) begin
                r_state <= S_IDLE;
                r_cnt   <= 4'd0;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign cpu_data_o  = w_cpu_rdata;
    assign cpu_stall_o = w_stall;
    assign cpu_err_o   = w_err;
    assign err_addr_o  = r_err_addr;
    assign slv_ce_o    = w_ce;
    assign slv_we_o    = w_we;
    assign slv_addr_o  = cpu_addr_i;
    assign slv_sel_o   = cpu_sel_i;
    assign slv_data_o  = cpu_data_i;

endmodule

`default_nettype wire

// File: tb/tb_sopc_data_bus.sv
//------------------------------------------------------------------------------
// Module      : tb_sopc_data_bus
// Description : Self-checking bench for sopc_data_bus against a cycle-count
//               reference model of the memory map.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sopc_data_bus;

    localparam int NSLV   = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [NSLV*ADDR_W-1:0] P_BASE =
        {32'h2000_0000, 32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NSLV*ADDR_W-1:0] P_MASK =
        {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000};
    localparam logic [NSLV*4-1:0] P_WAIT = {4'd2, 4'd1, 4'd3, 4'd0};

    logic [31:0] m_base [NSLV] = '{32'h0000_0000, 32'h1000_0000, 32'h0000_0000, 32'h2000_0000};
    logic [31:0] m_mask [NSLV] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_0000};
    int          m_wait [NSLV] = '{0, 3, 1, 2};

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cpu_ce;
    logic                   cpu_we;
    logic [ADDR_W-1:0]      cpu_addr;
    logic [DATA_W/8-1:0]    cpu_sel;
    logic [DATA_W-1:0]      cpu_wdata;
    logic [DATA_W-1:0]      cpu_rdata;
    logic                   cpu_stall;
    logic                   cpu_err;
    logic [ADDR_W-1:0]      err_addr;
    logic [NSLV-1:0]        slv_ce;
    logic                   slv_we;
    logic [ADDR_W-1:0]      slv_addr;
    logic [DATA_W/8-1:0]    slv_sel;
    logic [DATA_W-1:0]      slv_wdata;
    logic [NSLV*DATA_W-1:0] slv_rdata;
    logic [DATA_W-1:0]      sdata [NSLV];

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [31:0] exp_err_addr = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < NSLV; i++) slv_rdata[i*DATA_W +: DATA_W] = sdata[i];
    end

    sopc_data_bus #(
        .NSLV     (NSLV),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (P_BASE),
        .SLV_MASK (P_MASK),
        .SLV_WAIT (P_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_ce_i    (cpu_ce),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_sel_i   (cpu_sel),
        .cpu_data_i  (cpu_wdata),
        .cpu_data_o  (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .cpu_err_o   (cpu_err),
        .err_addr_o  (err_addr),
        .slv_ce_o    (slv_ce),
        .slv_we_o    (slv_we),
        .slv_addr_o  (slv_addr),
        .slv_sel_o   (slv_sel),
        .slv_data_o  (slv_wdata),
        .slv_data_i  (slv_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lowest-indexed slave whose masked base equals the masked address; -1 if none.
    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NSLV; i++)
            if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
        return -1;
    endfunction

    task automatic randomize_slaves();
        for (int i = 0; i < NSLV; i++) sdata[i] = $urandom;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ce"},    64'(slv_ce),    64'd0);
        chk({tag, "_we"},    64'(slv_we),    64'd0);
        chk({tag, "_stall"}, 64'(cpu_stall), 64'd0);
        chk({tag, "_err"},   64'(cpu_err),   64'd0);
        chk({tag, "_rdata"}, 64'(cpu_rdata), 64'd0);
    endtask

    task automatic idle_cycle();
        cpu_ce = 1'b0;
        @(negedge clk);
        check_quiet("idle");
        chk("idle_err_addr", 64'(err_addr), 64'(exp_err_addr));
        @(posedge clk); #1;
    endtask

    // An access to a slave with wait count W takes W stall cycles plus one
    // completion cycle; abort_at (1..W) drops the request in that cycle.
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel,
                          input int abort_at);
        int   k;
        int   w;
        logic last;
        cpu_ce = 1'b1; cpu_we = we; cpu_addr = addr; cpu_sel = sel; cpu_wdata = wdata;
        k = decode(addr);
        if (k < 0) begin
            @(negedge clk);
            chk("unmap_err",   64'(cpu_err),   64'd1);
            chk("unmap_stall", 64'(cpu_stall), 64'd0);
            chk("unmap_ce",    64'(slv_ce),    64'd0);
            chk("unmap_we",    64'(slv_we),    64'd0);
            chk("unmap_rdata", 64'(cpu_rdata), 64'd0);
            chk("unmap_err_addr_hold", 64'(err_addr), 64'(exp_err_addr));
            @(posedge clk); #1;
            exp_err_addr = addr;
            return;
        end
        w = m_wait[k];
        for (int c = 0; c <= w; c++) begin
            if (c == abort_at) cpu_ce = 1'b0;
            @(negedge clk);
            if (c == abort_at) begin
                check_quiet("abort");
                @(posedge clk); #1;
                return;
            end
            last = (c == w);
            chk("acc_ce",    64'(slv_ce),    64'd1 << k);
            chk("acc_stall", 64'(cpu_stall), 64'(!last));
            chk("acc_we",    64'(slv_we),    64'(last && we));
            chk("acc_rdata", 64'(cpu_rdata), (last && !we) ? 64'(sdata[k]) : 64'd0);
            chk("acc_err",   64'(cpu_err),   64'd0);
            if (c == 0) begin
                chk("bcast_addr", 64'(slv_addr),  64'(addr));
                chk("bcast_sel",  64'(slv_sel),   64'(sel));
                chk("bcast_data", 64'(slv_wdata), 64'(wdata));
                chk("acc_err_addr_hold", 64'(err_addr), 64'(exp_err_addr));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int          t0;
        int          k;
        int          ab;
        logic [31:0] a;

        randomize_slaves();
        sdata[0] = 32'hCAFE_F00D;
        rst = 1'b1; cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
        cpu_sel = 4'hF; cpu_wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0; cpu_ce = 1'b0;
        @(negedge clk);
        chk("reset_err_addr", 64'(err_addr), 64'd0);
        check_quiet("post_reset");
        @(posedge clk); #1;

        // Directed: zero-wait read, wait-state write, unmapped read, flush, overlap.
        randomize_slaves();
        sdata[0] = 32'h1234_5678;
        access(1'b0, 32'h0000_0010, 32'h0, 4'hF, -1);
        idle_cycle();
        access(1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 4'b1111, -1);
        idle_cycle();
        access(1'b0, 32'hF000_0000, 32'h0, 4'hF, -1);
        idle_cycle();
        chk("err_addr_loaded", 64'(err_addr), 64'h0000_0000_F000_0000);
        access(1'b1, 32'h1000_0040, 32'h0BAD_0BAD, 4'hF, 1);
        idle_cycle();
        randomize_slaves();
        access(1'b0, 32'h0000_0100, 32'h0, 4'hF, -1);
        chk("overlap_low_wins", 64'(decode(32'h0000_0100)), 64'd0);

        // Back-to-back: W=2 read then W=0 read with no bubble between them.
        t0 = cyc;
        access(1'b0, 32'h2000_0008, 32'h0, 4'hF, -1);
        access(1'b0, 32'h0000_0020, 32'h0, 4'hF, -1);
        chk("b2b_cycles", 64'(cyc - t0), 64'(m_wait[3] + 1 + 1));
        idle_cycle();

        // Reset in the second WAIT cycle of a W=3 write.
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1000_0004;
        cpu_sel = 4'hF; cpu_wdata = 32'h7777_0000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rmw_stall", 64'(cpu_stall), 64'd1);
            chk("rmw_we",    64'(slv_we),    64'd0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check_quiet("rmw_in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err_addr = '0;
        idle_cycle();
        access(1'b0, 32'h0000_0044, 32'h0, 4'hF, -1);

        // Randomized traffic across mapped, unmapped and flushed accesses.
        for (int n = 0; n < 60; n++) begin
            randomize_slaves();
            case ($urandom_range(0, 3))
                0:       a = {16'h0000, 16'($urandom)};
                1:       a = {16'h1000, 16'($urandom)};
                2:       a = {16'h2000, 16'($urandom)};
                default: a = $urandom;
            endcase
            k  = decode(a);
            ab = -1;
            if (k >= 0 && m_wait[k] > 0 && $urandom_range(0, 3) == 0)
                ab = int'($urandom_range(1, m_wait[k]));
            access(1'($urandom), a, $urandom, 4'($urandom), ab);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
